// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the NAND CPU register file and writeback path.
package regfile_writeback_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int CNT_W      = 16;

  typedef enum logic {DUMP_IDLE, DUMP_ACTIVE} dump_state_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bundle from the writeback glue into the register file.
interface writeback_ifc #(
  parameter int ADDR_W = regfile_writeback_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_writeback_pkg::DATA_W
);

  logic              valid;
  logic              use_rw;
  logic [ADDR_W-1:0] rw_addr;
  logic [DATA_W-1:0] data;
  logic              write_ps;
  logic              ps;

  modport out (output valid, use_rw, rw_addr, data, write_ps, ps);
  modport in  (input  valid, use_rw, rw_addr, data, write_ps, ps);

endinterface

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks an index across every register, one per cycle,
// after a request. Requests arriving while a walk is in progress are dropped.
module regfile_dump_seq #(
  parameter int NUM_REGS = regfile_writeback_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_writeback_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req,
  output logic [ADDR_W-1:0] idx,
  output logic              active
);
  import regfile_writeback_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t state;

  // State and index advance together; the index is held at 0 when idle
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= DUMP_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          idx <= '0;
          if (req) state <= DUMP_ACTIVE;
        end
        DUMP_ACTIVE: begin
          if (idx == LAST_IDX) begin
            state <= DUMP_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= DUMP_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign active = (state == DUMP_ACTIVE);

endmodule

// File: rtl/regfile_writeback.sv
// Architectural register file, predicate state and retired counter, with
// write-bypassed read ports and a sequential debug dump port.
module regfile_writeback #(
  parameter int NUM_REGS = regfile_writeback_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_writeback_pkg::REG_ADDR_W,
  parameter int DATA_W   = regfile_writeback_pkg::DATA_W,
  parameter int CNT_W    = regfile_writeback_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              n_rst,
  writeback_ifc.in          i_wb,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rt,
  output logic              ps,
  output logic [CNT_W-1:0]  retired,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);
  import regfile_writeback_pkg::*;

  // Read port numbering: 0 = ra, 1 = rt, 2 = dump
  localparam int NUM_RD = 3;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              reg_wr;
  logic              ps_wr;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_active;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];

  assign reg_wr = i_wb.valid & i_wb.use_rw;
  assign ps_wr  = i_wb.valid & i_wb.write_ps;

  // Register array: cleared on reset (so not mapped to block RAM), one write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!n_rst) begin
        regs[i] <= '0;
      end else if (reg_wr && (i_wb.rw_addr == ADDR_W'(i))) begin
        regs[i] <= i_wb.data;
      end
    end
  end

  // Predicate state and retired-instruction counter, both gated by valid
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ps      <= 1'b0;
      retired <= '0;
    end else begin
      if (ps_wr) ps <= i_wb.ps;
      if (i_wb.valid) retired <= retired + 1'b1;
    end
  end

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rt_addr;
  assign rd_addr[2] = dump_idx;

  // Every read port forwards the in-flight write so the core never sees a stale value
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_data[gi] = (reg_wr && (i_wb.rw_addr == rd_addr[gi])) ? i_wb.data
                                                                      : regs[rd_addr[gi]];
    end
  endgenerate

  assign ra = rd_data[0];
  assign rt = rd_data[1];

  regfile_dump_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_dump_seq (
    .clk    (clk),
    .n_rst  (n_rst),
    .req    (dump_req),
    .idx    (dump_idx),
    .active (dump_active)
  );

  // Dump outputs are forced to zero outside an active walk
  assign dump_busy  = dump_active;
  assign dump_valid = dump_active;
  assign dump_addr  = dump_active ? dump_idx : '0;
  assign dump_data  = dump_active ? rd_data[2] : '0;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_regfile_writeback;

  localparam int NR = 16;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk;
  logic          n_rst;
  logic [AW-1:0] ra_addr, rt_addr;
  logic [DW-1:0] ra, rt;
  logic          ps;
  logic [CW-1:0] retired;
  logic          dump_req;
  logic          dump_busy, dump_valid;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;

  writeback_ifc #(.ADDR_W(AW), .DATA_W(DW)) wb ();

  regfile_writeback #(
    .NUM_REGS (NR), .ADDR_W (AW), .DATA_W (DW), .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_wb       (wb),
    .ra_addr    (ra_addr),
    .rt_addr    (rt_addr),
    .ra         (ra),
    .rt         (rt),
    .ps         (ps),
    .retired    (retired),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else if (verbose) begin
      $display("check %s: 0x%0h ok", name, act);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp(name, act, exp, 1'b1);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  logic          m_ps = 1'b0;
  logic [CW-1:0] m_ret = '0;
  int            cyc = 0;
  int            dump_start = -100000;
  bit            chk_en = 1'b0;

  // A dump occupies the NR cycles starting at dump_start
  function automatic bit in_dump(input int c);
    return (c >= dump_start) && (c < dump_start + NR);
  endfunction

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    if (wb.valid && wb.use_rw && wb.rw_addr == a) return wb.data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_ps       = 1'b0;
      m_ret      = '0;
      dump_start = -100000;
      chk_en     = 1'b1;
    end else begin
      if (dump_req && !in_dump(cyc)) dump_start = cyc + 1;
      if (wb.valid) begin
        if (wb.use_rw) m_regs[wb.rw_addr] = wb.data;
        if (wb.write_ps) m_ps = wb.ps;
        m_ret = m_ret + 1'b1;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    bit            dv;
    logic [AW-1:0] da;
    logic [DW-1:0] dd;
    if (chk_en) begin
      dv = in_dump(cyc);
      da = dv ? AW'(cyc - dump_start) : '0;
      dd = dv ? mread(da) : '0;
      cmp("ra",         32'(ra),         32'(mread(ra_addr)), 1'b0);
      cmp("rt",         32'(rt),         32'(mread(rt_addr)), 1'b0);
      cmp("ps",         32'(ps),         32'(m_ps),           1'b0);
      cmp("retired",    32'(retired),    32'(m_ret),          1'b0);
      cmp("dump_busy",  32'(dump_busy),  32'(dv),             1'b0);
      cmp("dump_valid", 32'(dump_valid), 32'(dv),             1'b0);
      cmp("dump_addr",  32'(dump_addr),  32'(da),             1'b0);
      cmp("dump_data",  32'(dump_data),  32'(dd),             1'b0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_wb();
    wb.valid = 1'b0; wb.use_rw = 1'b0; wb.write_ps = 1'b0;
    wb.ps = 1'b0; wb.rw_addr = '0; wb.data = '0;
  endtask

  task automatic wr(input int a, input int d);
    wb.valid = 1'b1; wb.use_rw = 1'b1; wb.write_ps = 1'b0;
    wb.rw_addr = AW'(a); wb.data = DW'(d);
  endtask

  initial begin
    n_rst = 1'b0; dump_req = 1'b0; ra_addr = '0; rt_addr = '0;
    idle_wb();
    next(); next();
    n_rst = 1'b1;

    // 1: reset values
    for (int i = 0; i < NR; i++) begin
      ra_addr = AW'(i); rt_addr = AW'(NR - 1 - i);
      neg();
      lit("rst_ra", 32'(ra), 0);
      lit("rst_rt", 32'(rt), 0);
      if (i == 0) begin
        lit("rst_ps", 32'(ps), 0);
        lit("rst_retired", 32'(retired), 0);
        lit("rst_dump_busy", 32'(dump_busy), 0);
      end
      next();
    end

    // 2: write, bypass, stored value, use_rw=0 leaves register alone
    wr(3, 'hBEEF); ra_addr = 3;
    neg(); lit("wr_bypass", 32'(ra), 'hBEEF);
    next(); idle_wb();
    neg(); lit("wr_stored", 32'(ra), 'hBEEF);
    next();
    wb.valid = 1'b1; wb.use_rw = 1'b0; wb.rw_addr = 3; wb.data = 16'h1111;
    next(); idle_wb();
    neg(); lit("no_use_rw", 32'(ra), 'hBEEF); lit("retired_2", 32'(retired), 2);
    next();

    // 3: combined write, then an invalid cycle changes nothing
    wr(5, 'h0001); wb.write_ps = 1'b1; wb.ps = 1'b1;
    next(); idle_wb(); ra_addr = 5;
    neg();
    lit("comb_ps", 32'(ps), 1); lit("comb_r5", 32'(ra), 1); lit("retired_3", 32'(retired), 3);
    wb.valid = 1'b0; wb.use_rw = 1'b1; wb.write_ps = 1'b1; wb.ps = 1'b0;
    wb.rw_addr = 5; wb.data = 16'hDEAD;
    next(); idle_wb();
    neg();
    lit("gated_ps", 32'(ps), 1); lit("gated_r5", 32'(ra), 1); lit("gated_retired", 32'(retired), 3);
    next();

    // 4: clean dump of preloaded registers
    for (int i = 0; i < NR; i++) begin
      wr(i, i * 'h0101);
      next();
    end
    idle_wb();
    dump_req = 1'b1;
    next(); dump_req = 1'b0;
    for (int k = 0; k < NR; k++) begin
      neg();
      lit("dump_valid", 32'(dump_valid), 1);
      lit("dump_addr", 32'(dump_addr), 32'(k));
      lit("dump_data", 32'(dump_data), 32'(k * 'h0101));
      next();
    end
    neg();
    lit("dump_busy_fall", 32'(dump_busy), 0); lit("dump_valid_fall", 32'(dump_valid), 0);

    // 5: new request in the first idle cycle; write and re-request during the dump
    dump_req = 1'b1;
    next(); dump_req = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (k == 5) dump_req = 1'b1;
      if (k == 10) wr(10, 'h1234);
      neg();
      lit("dump2_addr", 32'(dump_addr), 32'(k));
      lit("dump2_data", 32'(dump_data), (k == 10) ? 'h1234 : 32'(k * 'h0101));
      next();
      dump_req = 1'b0; idle_wb();
    end
    neg();
    lit("dump2_end_valid", 32'(dump_valid), 0); lit("retired_20", 32'(retired), 20);
    next();
    neg(); lit("dump2_no_restart", 32'(dump_busy), 0);

    // 6a: reset in the middle of a dump
    dump_req = 1'b1;
    next(); dump_req = 1'b0;
    repeat (7) next();
    neg(); lit("mid_addr", 32'(dump_addr), 7);
    n_rst = 1'b0;
    next(); n_rst = 1'b1;
    neg();
    lit("abort_valid", 32'(dump_valid), 0); lit("abort_busy", 32'(dump_busy), 0);
    for (int i = 0; i < NR; i++) begin
      ra_addr = AW'(i); rt_addr = AW'(i);
      neg();
      lit("abort_ra", 32'(ra), 0);
      lit("abort_valid_held", 32'(dump_valid), 0);
      next();
    end

    // 6b: retired counter wrap
    wb.valid = 1'b1;
    repeat (65535) next();
    idle_wb();
    neg(); lit("retired_max", 32'(retired), 'hFFFF);
    next(); wb.valid = 1'b1;
    next(); idle_wb();
    neg(); lit("retired_wrap", 32'(retired), 0);
    next();

    // Randomized traffic, including dump requests and occasional resets
    for (int i = 0; i < 600; i++) begin
      wb.valid    = 1'($urandom_range(0, 1));
      wb.use_rw   = 1'($urandom_range(0, 1));
      wb.write_ps = 1'($urandom_range(0, 1));
      wb.ps       = 1'($urandom_range(0, 1));
      wb.rw_addr  = AW'($urandom_range(0, NR - 1));
      wb.data     = DW'($urandom);
      ra_addr     = ($urandom_range(0, 1) == 0) ? wb.rw_addr : AW'($urandom_range(0, NR - 1));
      rt_addr     = ($urandom_range(0, 1) == 0) ? wb.rw_addr : AW'($urandom_range(0, NR - 1));
      dump_req    = ($urandom_range(0, 11) == 0);
      n_rst       = ($urandom_range(0, 149) != 0);
      next();
    end
    idle_wb(); dump_req = 1'b0; n_rst = 1'b1;
    repeat (4) next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
